// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and default operand width
package addsub_pkg;

  localparam int ADDSUB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_unit.sv
// rtl/addsub_unit.sv - combinational unsigned add / magnitude-subtract
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int W = ADDSUB_W
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         M,
  output logic [W:0]   S,
  output logic         sign
);

  logic [W:0] w_a;
  logic [W:0] w_b;

  assign w_a = {1'b0, A};
  assign w_b = {1'b0, B};

  // Subtract always yields a magnitude; sign records which operand was larger.
  always_comb begin
    S    = '0;
    sign = 1'b0;
    if (!M) begin
      S = w_a + w_b;
    end else if (A < B) begin
      S    = w_b - w_a;
      sign = 1'b1;
    end else begin
      S = w_a - w_b;
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin front end to one add/sub unit
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int W = ADDSUB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         m0,
  input  logic         m1,
  output logic         ack0,
  output logic         ack1,
  output logic [W:0]   s,
  output logic         sign,
  output logic         busy,
  output logic         gnt_id
);

  state_t       r_state;
  state_t       w_next;
  logic         r_prio;
  logic         r_gnt_id;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_m;
  logic [W:0]   r_s;
  logic         r_sign;

  logic         w_grant;
  logic         w_pick;
  logic [W:0]   w_s;
  logic         w_sign;

  addsub_unit #(.W(W)) u_unit (
    .A    (r_a),
    .B    (r_b),
    .M    (r_m),
    .S    (w_s),
    .sign (w_sign)
  );

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_pick  = r_prio;
    ack0    = 1'b0;
    ack1    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_grant = 1'b1;
          // Pointer only matters on contention; a lone requester always wins.
          w_pick  = (req0 && req1) ? r_prio : req1;
          w_next  = EXEC;
        end
      end
      EXEC: w_next = DONE;
      DONE: begin
        ack0   = ~r_gnt_id;
        ack1   = r_gnt_id;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_prio   <= 1'b0;
      r_gnt_id <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= 1'b0;
      r_s      <= '0;
      r_sign   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gnt_id <= w_pick;
        r_prio   <= ~w_pick;
        r_a      <= w_pick ? a1 : a0;
        r_b      <= w_pick ? b1 : b0;
        r_m      <= w_pick ? m1 : m0;
      end
      if (r_state == EXEC) begin
        r_s    <= w_s;
        r_sign <= w_sign;
      end
    end
  end

  assign s      = r_s;
  assign sign   = r_sign;
  assign busy   = (r_state != IDLE);
  assign gnt_id = r_gnt_id;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed and random checks against a transaction-level model
module tb_addsub_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         m0 = 1'b0, m1 = 1'b0;
  logic         ack0, ack1, sign, busy, gnt_id;
  logic [W:0]   s;

  int total = 0;
  int bad = 0;

  // Model: cycles left in the current operation (0 idle, 2 computing, 1 acking).
  int m_left, m_prio, m_gnt, m_s, m_sign, p_s, p_sign;

  addsub_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .m0(m0), .m1(m1),
    .ack0(ack0), .ack1(ack1),
    .s(s), .sign(sign), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_prio = 0; m_gnt = 0; m_s = 0; m_sign = 0; p_s = 0; p_sign = 0;
  endtask

  task automatic model_result(input int a, input int b, input int m);
    int d;
    d = a - b;
    if (m == 0) begin p_s = a + b; p_sign = 0; end
    else if (d < 0) begin p_s = -d; p_sign = 1; end
    else begin p_s = d; p_sign = 0; end
  endtask

  task automatic model_edge();
    int pick;
    if (!rst_n) begin
      model_reset();
    end else if (m_left == 0) begin
      if (req0 || req1) begin
        pick = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
        m_gnt = pick;
        m_prio = 1 - pick;
        if (pick == 0) model_result(int'(a0), int'(b0), int'(m0));
        else model_result(int'(a1), int'(b1), int'(m1));
        m_left = 2;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin m_s = p_s; m_sign = p_sign; end
    end
  endtask

  task automatic check_all();
    chk("ack0", 32'(ack0), 32'(m_left == 1 && m_gnt == 0));
    chk("ack1", 32'(ack1), 32'(m_left == 1 && m_gnt == 1));
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
    chk("s", 32'(s), 32'(m_s));
    chk("sign", 32'(sign), 32'(m_sign));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_ack(input string tag, input int id, input int es, input int esg, input int ecnt);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ack0 || ack1) && n < 12);
    chk({tag, "_ack"}, 32'(id == 0 ? ack0 : ack1), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(ecnt));
    chk({tag, "_s"}, 32'(s), 32'(es));
    chk({tag, "_sign"}, 32'(sign), 32'(esg));
    chk({tag, "_gnt"}, 32'(gnt_id), 32'(id));
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single add on requester 0.
    req0 = 1; a0 = 9; b0 = 8; m0 = 0;
    wait_ack("r0add", 0, 17, 0, 2);
    req0 = 0;
    tick();

    // Magnitude subtract with negative result on requester 1.
    req1 = 1; a1 = 3; b1 = 7; m1 = 1;
    wait_ack("r1sub", 1, 4, 1, 2);
    req1 = 0;
    tick();

    // Simultaneous requests straight after reset: pointer starts at 0.
    @(posedge clk); #1;
    rst_n = 0; model_reset(); #1; check_all();
    @(posedge clk); model_edge(); #1;
    rst_n = 1;
    req0 = 1; a0 = 15; b0 = 15; m0 = 0;
    req1 = 1; a1 = 5;  b1 = 5;  m1 = 1;
    wait_ack("both0", 0, 30, 0, 2);
    req0 = 0;
    wait_ack("both1", 1, 0, 0, 3);
    req1 = 0;
    tick();

    // Both held: alternating grants, one idle cycle between operations.
    req0 = 1; req1 = 1; a0 = 1; b0 = 2; m0 = 0; a1 = 6; b1 = 2; m1 = 1;
    wait_ack("alt0", 0, 3, 0, 2);
    wait_ack("alt1", 1, 4, 0, 3);
    tick();
    chk("alt_idle", 32'(busy), 32'd0);
    wait_ack("alt2", 0, 3, 0, 2);
    wait_ack("alt3", 1, 4, 0, 3);
    req0 = 0; req1 = 0;
    tick();

    // Operands changed after grant must not affect the result.
    req0 = 1; a0 = 0; b0 = 15; m0 = 1;
    tick();
    a0 = 7; b0 = 3; m0 = 0;
    wait_ack("latch", 0, 15, 1, 1);
    req0 = 0;
    tick();

    // Reset while computing aborts the operation.
    req0 = 1; a0 = 4; b0 = 4; m0 = 0;
    tick();
    chk("abort_busy", 32'(busy), 32'd1);
    rst_n = 0; model_reset(); req0 = 0; #1;
    check_all();
    chk("abort_s", 32'(s), 32'd0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) tick();
    req0 = 1; req1 = 1; a0 = 2; b0 = 9; m0 = 1; a1 = 1; b1 = 1; m1 = 0;
    wait_ack("post_rst", 0, 7, 1, 2);
    req0 = 0; req1 = 0;
    tick();

    // Random traffic, including reqs that drop before being served.
    for (int i = 0; i < 400; i++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      a0 = W'($urandom); b0 = W'($urandom); m0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); m1 = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  level request; held high until the matching ack.
REQ-005 SHALL have ports a0, b0, a1, b1  input  W each  operands of requester 0 / 1.
REQ-006 SHALL have ports m0, m1  input  1 each  mode: 0 = A+B, 1 = A-B (magnitude).
REQ-007 SHALL have ports ack0, ack1  output  1 each  one-cycle pulse; result is valid in that cycle.
REQ-008 SHALL have port s  output  W+1  result magnitude.
REQ-009 SHALL have port sign  output  1  1 = negative result.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port gnt_id  output  1  index of the requester in service or last served.

Function
REQ-012 SHALL implement the FSM states IDLE, EXEC and DONE.
REQ-013 In IDLE with any req high, SHALL grant one requester, latch its a/b/m into internal registers, set gnt_id and go to EXEC on the same edge.
REQ-014 In IDLE with no req high, SHALL stay in IDLE with all registers unchanged.
REQ-015 SHALL keep a priority pointer prio with reset value 0; when both reqs are high in IDLE, it SHALL grant requester prio.
REQ-016 When only one req is high in IDLE, it SHALL grant that requester regardless of prio.
REQ-017 After every grant, prio SHALL be set to the requester that was not granted.
REQ-018 In EXEC, SHALL compute on the latched operands only, register s and sign, and go to DONE.
- Later changes on a*/b*/m* inputs SHALL be ignored.
REQ-019 In DONE, SHALL assert ack[gnt_id] = 1 for exactly one cycle with s/sign valid, then go to IDLE.
REQ-020 Latency SHALL be: grant edge at cycle N, ack high during cycle N+2.
- Maximum throughput SHALL be one operation per 3 cycles.
REQ-021 s and sign SHALL hold their last value until the next EXEC.
- Both acks SHALL be 0 in all states except DONE.
REQ-022 Arithmetic SHALL be unsigned and zero-extended to W+1 bits:
- m=0: s = A+B, sign = 0.
- m=1 and A<B: s = B-A, sign = 1.
- m=1 and A>=B: s = A-B, sign = 0.
REQ-023 If a req is still high in the IDLE cycle after its ack, SHALL treat it as a new request; the requester is responsible for dropping req.
REQ-024 A req that falls while it is not granted SHALL be dropped with no ack.

Reset
REQ-025 rst_n low SHALL immediately force: state = IDLE, prio = 0, gnt_id = 0, s = 0, sign = 0, ack0 = ack1 = 0, busy = 0, latched operands = 0.
REQ-026 A reset during EXEC or DONE SHALL abort the operation; no ack for it SHALL be issued after reset is released.
REQ-027 The first edge with rst_n high SHALL evaluate requests as a normal IDLE cycle.

Structure
REQ-028 The state encoding (IDLE/EXEC/DONE) and the default W SHALL live in shared package addsub_pkg.
REQ-029 The arithmetic SHALL be a combinational sub-module addsub_unit (ports A, B, M -> S, sign) instantiated once.
- Everything else SHALL be in addsub_arbiter.

Verification
REQ-030 req0, a0=9, b0=8, m0=0 -> ack0 two cycles after grant, s=17, sign=0, gnt_id=0.
REQ-031 req1, a1=3, b1=7, m1=1 -> ack1, s=4, sign=1.
REQ-032 Both reqs raised in the same cycle after reset (a0=15, b0=15, m0=0; a1=5, b1=5, m1=1) -> ack0 first with s=30, sign=0; ack1 three cycles later with s=0, sign=0.
REQ-033 req0 and req1 held high continuously -> grants alternate 0,1,0,1; one ack every 3 cycles; busy low exactly one cycle between operations.
REQ-034 a0=0, b0=15, m0=1; operands changed during EXEC -> s=15, sign=1 (latched values used).
REQ-035 rst_n pulsed low during EXEC -> no ack; s=0, sign=0, busy=0; next request with both reqs high grants requester 0.
